_bus_arb: RTL
=============

_BUS_ARB -- requirements
Module: _bus_arb

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of bus sources (2..16).
REQ-002 SHALL have parameter W, default 32, meaning data width per source (multiple of 8, 8..64).
REQ-003 SHALL have parameter MAXHOLD, default 0, meaning maximum tenure in cycles before forced rotation (0 = unlimited).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port req  input  N  per-source bus request, active-high, level-held for the whole transfer.
REQ-007 SHALL have port a  input  W*N  source data, source i on bits [i*W+W-1 : i*W].
REQ-008 SHALL have port lock  input  N  per-source lock that suppresses forced rotation (present only when the macro in REQ-027 is defined).
REQ-009 SHALL have port gnt  output  N  registered one-hot grant, active-high.
REQ-010 SHALL have port g_n  output  N  bitwise inverse of gnt, for driving active-low byte-lane buffer enables.
REQ-011 SHALL have port owner  output  clog2(N)  index of the current grant holder.
REQ-012 SHALL have port y  output  W  registered bus data.
REQ-013 SHALL have port valid  output  1  y holds data of a granted source.

Function
REQ-014 SHALL implement two states: IDLE (gnt = 0) and BUSY (exactly one gnt bit set).
REQ-015 IDLE: if req != 0 at edge k, SHALL go BUSY with gnt set to the round-robin winner from edge k+1; else stay IDLE.
REQ-016 Round-robin SHALL search from index ptr upward with wrap N-1 -> 0; first set req bit wins.
REQ-017 On every new grant to source i, ptr SHALL become (i+1) mod N.
REQ-018 BUSY, owner's req still high, no forced rotation: gnt, owner SHALL hold unchanged.
REQ-019 BUSY, owner's req low: if any other req is high, grant SHALL move to the next winner on the following edge with no idle cycle; else state SHALL return to IDLE with gnt = 0.
REQ-020 Hold counter SHALL clear on each new grant and increment each BUSY cycle, saturating at MAXHOLD.
REQ-021 MAXHOLD > 0, counter = MAXHOLD-1, another req pending: grant SHALL rotate to the next winner on the next edge even if the owner's req is still high; with no other req pending the owner SHALL keep the grant.
REQ-022 y SHALL equal the slice of a selected by gnt, registered one cycle after gnt (y at edge k+1 reflects a sampled at edge k+1 while gnt was valid during cycle k+1).
REQ-023 valid SHALL be gnt != 0 delayed one cycle; when valid = 0, y SHALL hold its last value.
REQ-024 A req bit rising in the same cycle as the owner releases SHALL be eligible in that cycle's arbitration.

Reset
REQ-025 rst high at an edge SHALL force gnt = 0, g_n = all ones, owner = 0, y = 0, valid = 0, ptr = 0, hold counter = 0, state IDLE, regardless of state, including mid-tenure.
REQ-026 The first arbitration after rst deasserts SHALL use ptr = 0 (source 0 highest priority).

Configuration
REQ-027 With BUS_ARB_LOCK_EN defined, the lock port SHALL exist and owner's lock bit high SHALL inhibit the forced rotation of REQ-021 (counter stays saturated).
REQ-028 Without BUS_ARB_LOCK_EN, the lock port SHALL be absent and REQ-021 SHALL always apply.

Verification
REQ-029 Reset then req=8'h05, N=8 -> gnt=8'h01 one cycle later, owner=0; next cycle y = a[31:0], valid=1.
REQ-030 req 8'h05 held, owner 0 drops req -> next cycle gnt=8'h04 with no gnt=0 cycle; ptr=3.
REQ-031 MAXHOLD=4, req=8'h03 held continuously -> gnt alternates 8'h01 for 4 cycles, 8'h02 for 4 cycles, repeating.
REQ-032 MAXHOLD=4, BUS_ARB_LOCK_EN, lock=8'h01, req=8'h03 -> gnt stays 8'h01 indefinitely; lock cleared -> gnt=8'h02 next cycle.
REQ-033 rst asserted mid-tenure with gnt=8'h10 -> next cycle gnt=0, g_n=8'hFF, y=0, valid=0; later req=8'h90 -> gnt=8'h10 (ptr reset to 0).
REQ-034 All req released while BUSY -> IDLE with gnt=0 next cycle, valid=0 one cycle after that, y holds last value.

Source files
------------

// File: rtl/_bus_arb.sv
// Round-robin bus arbiter: N sources, registered one-hot grant and registered bus data.
// Optional owner lock against forced rotation is enabled by defining BUS_ARB_LOCK_EN.
module _bus_arb #(
  parameter int N       = 8,
  parameter int W       = 32,
  parameter int MAXHOLD = 0,
  localparam int OW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [W*N-1:0]  a,
`ifdef BUS_ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    g_n,
  output logic [OW-1:0]   owner,
  output logic [W-1:0]    y,
  output logic            valid
);

  localparam int HW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAXHOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAXHOLD > 0) ? MAXHOLD - 1 : 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [W-1:0]    y_q;
  logic            valid_q;

  logic [N-1:0]    cand;
  logic            found;
  logic [OW-1:0]   win;
  logic [OW-1:0]   ptr_nxt;
  logic [N-1:0]    win_oh;
  logic            owner_req;
  logic            owner_lock;
  logic            force_rot;
  logic [W-1:0]    bus_sel;

  // While busy the owner is excluded, so a forced rotation never re-picks it.
  always_comb begin
    cand  = (state_q == BUSY) ? (req & ~gnt_q) : req;
    found = 1'b0;
    win   = '0;
    for (int off = 0; off < N; off++) begin
      if (!found && cand[(int'(ptr_q) + off) % N]) begin
        found = 1'b1;
        win   = OW'((int'(ptr_q) + off) % N);
      end
    end
    ptr_nxt = (win == OW'(N - 1)) ? '0 : win + 1'b1;
    win_oh  = '0;
    win_oh[win] = 1'b1;
  end

`ifdef BUS_ARB_LOCK_EN
  assign owner_lock = lock[owner_q];
`else
  assign owner_lock = 1'b0;
`endif

  assign owner_req = |(req & gnt_q);
  // A saturated counter still counts as expired, so clearing a lock rotates at once.
  assign force_rot = (MAXHOLD > 0) && (hold_q >= HOLD_LAST) && (|cand) && !owner_lock;

  // NOTE: every output of a combinational block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if ((state_q == BUSY) && (MAXHOLD > 0) && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = win_oh;
          owner_d = win;
          ptr_d   = ptr_nxt;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (!owner_req || force_rot) begin
          if (found) begin
            gnt_d   = win_oh;
            owner_d = win;
            ptr_d   = ptr_nxt;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) bus_sel = bus_sel | a[i*W +: W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      valid_q <= |gnt_q;
      if (|gnt_q) y_q <= bus_sel;
    end
  end

  assign gnt   = gnt_q;
  assign g_n   = ~gnt_q;
  assign owner = owner_q;
  assign y     = y_q;
  assign valid = valid_q;

endmodule
